// File: rtl/bank_timing_tracker.sv
// Per-bank DRAM timing-constraint tracker: watches issued commands, keeps per-bank and
// rank-level countdowns, reports per-bank command legality and flags illegal issues.
module bank_timing_tracker #(
    parameter int NUM_BANKS = 8,
    parameter int BA_BITS   = 3,
    parameter int CNT_W     = 7,
    parameter int T_RCD     = 11,
    parameter int T_RP      = 11,
    parameter int T_RAS     = 28,
    parameter int T_RC      = 39,
    parameter int T_RRD     = 6,
    parameter int T_CCD     = 4,
    parameter int T_RTP     = 6,
    parameter int T_WTP     = 24,
    parameter int T_RFC     = 88
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    input  logic [3:0]           cmd,
    input  logic [BA_BITS-1:0]   cmd_bank,
    output logic [NUM_BANKS-1:0] act_ok,
    output logic [NUM_BANKS-1:0] rw_ok,
    output logic [NUM_BANKS-1:0] pre_ok,
    output logic                 ref_ok,
    output logic [NUM_BANKS-1:0] bank_open,
    output logic                 viol,
    output logic [BA_BITS-1:0]   viol_bank,
    output logic                 viol_sticky
);

    typedef enum logic [3:0] {
        CMD_NOP       = 4'd0,
        CMD_READ      = 4'd1,
        CMD_WRITE     = 4'd2,
        CMD_POWER_D   = 4'd3,
        CMD_POWER_U   = 4'd4,
        CMD_REFRESH   = 4'd5,
        CMD_ACTIVE    = 4'd6,
        CMD_PRECHARGE = 4'd7,
        CMD_RDA       = 4'd8,
        CMD_WRA       = 4'd9
    } sch_cmd_t;

    localparam int CNT_MAX = 2 ** CNT_W;

    // Elaboration-time sanity checks on the parameter set.
    if (NUM_BANKS < 1 || NUM_BANKS > 2 ** BA_BITS) begin : g_chk_banks
        $fatal(1, "bank_timing_tracker: NUM_BANKS does not fit BA_BITS");
    end
    if (T_RCD < 1 || T_RCD > CNT_MAX || T_RP  < 1 || T_RP  > CNT_MAX ||
        T_RAS < 1 || T_RAS > CNT_MAX || T_RC  < 1 || T_RC  > CNT_MAX ||
        T_RRD < 1 || T_RRD > CNT_MAX || T_CCD < 1 || T_CCD > CNT_MAX ||
        T_RTP < 1 || T_RTP > CNT_MAX || T_WTP < 1 || T_WTP > CNT_MAX ||
        T_RFC < 1 || T_RFC > CNT_MAX) begin : g_chk_timing
        $fatal(1, "bank_timing_tracker: timing parameter out of counter range");
    end
    if (T_RTP + T_RP > CNT_MAX || T_WTP + T_RP > CNT_MAX) begin : g_chk_auto_pre
        $fatal(1, "bank_timing_tracker: auto-precharge window exceeds counter range");
    end

    localparam logic [CNT_W-1:0] L_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] L_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] L_RAS = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0] L_RC  = CNT_W'(T_RC - 1);
    localparam logic [CNT_W-1:0] L_RRD = CNT_W'(T_RRD - 1);
    localparam logic [CNT_W-1:0] L_CCD = CNT_W'(T_CCD - 1);
    localparam logic [CNT_W-1:0] L_RTP = CNT_W'(T_RTP - 1);
    localparam logic [CNT_W-1:0] L_WTP = CNT_W'(T_WTP - 1);
    localparam logic [CNT_W-1:0] L_RFC = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W:0]   S_RDA = (CNT_W+1)'(T_RTP + T_RP - 1);
    localparam logic [CNT_W:0]   S_WRA = (CNT_W+1)'(T_WTP + T_RP - 1);
    localparam logic [CNT_W-1:0] L_RDA = S_RDA[CNT_W-1:0];
    localparam logic [CNT_W-1:0] L_WRA = S_WRA[CNT_W-1:0];
    localparam logic [BA_BITS:0] NB_LIM = (BA_BITS+1)'(NUM_BANKS);

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - CNT_W'(1);
    endfunction

    // Loads never shorten a pending constraint.
    function automatic logic [CNT_W-1:0] mx(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic                 bank_in_range;
    logic                 is_col, is_bank_cmd, is_illegal;
    logic                 act_go, col_go, ref_go;
    logic [NUM_BANKS-1:0] bank_sel;
    logic [NUM_BANKS-1:0] act_idle;
    logic [CNT_W-1:0]     rrd_q, rrd_d, ccd_q, ccd_d, rfc_q, rfc_d;
    logic                 viol_q, viol_d, viol_sticky_q;
    logic [BA_BITS-1:0]   viol_bank_q;

    assign bank_in_range = ({1'b0, cmd_bank} < NB_LIM);
    assign is_col        = cmd inside {CMD_READ, CMD_WRITE, CMD_RDA, CMD_WRA};
    assign is_bank_cmd   = is_col || cmd == CMD_ACTIVE || cmd == CMD_PRECHARGE;
    assign is_illegal    = (cmd > 4'd9);
    assign act_go        = cmd_valid && bank_in_range && cmd == CMD_ACTIVE;
    assign col_go        = cmd_valid && bank_in_range && is_col;
    assign ref_go        = cmd_valid && cmd == CMD_REFRESH;

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [CNT_W-1:0] act_q, act_d, rw_q, rw_d, pre_q, pre_d;
        logic             open_q, open_d;

        assign bank_sel[gi] = cmd_valid && bank_in_range && (cmd_bank == BA_BITS'(gi));

        always_comb begin
            act_d  = sat_dec(act_q);
            rw_d   = sat_dec(rw_q);
            pre_d  = sat_dec(pre_q);
            open_d = open_q;
            if (bank_sel[gi]) begin
                case (cmd)
                    CMD_ACTIVE: begin
                        open_d = 1'b1;
                        rw_d   = mx(rw_d, L_RCD);
                        pre_d  = mx(pre_d, L_RAS);
                        act_d  = mx(act_d, L_RC);
                    end
                    CMD_READ:  pre_d = mx(pre_d, L_RTP);
                    CMD_WRITE: pre_d = mx(pre_d, L_WTP);
                    CMD_RDA: begin
                        open_d = 1'b0;
                        act_d  = mx(act_d, L_RDA);
                    end
                    CMD_WRA: begin
                        open_d = 1'b0;
                        act_d  = mx(act_d, L_WRA);
                    end
                    CMD_PRECHARGE: begin
                        open_d = 1'b0;
                        act_d  = mx(act_d, L_RP);
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                act_q  <= '0;
                rw_q   <= '0;
                pre_q  <= '0;
                open_q <= 1'b0;
            end else begin
                act_q  <= act_d;
                rw_q   <= rw_d;
                pre_q  <= pre_d;
                open_q <= open_d;
            end
        end

        assign bank_open[gi] = open_q;
        assign act_idle[gi]  = (act_q == '0);
        assign act_ok[gi]    = !open_q && act_q == '0 && rrd_q == '0 && rfc_q == '0;
        assign rw_ok[gi]     = open_q && rw_q == '0 && ccd_q == '0;
        assign pre_ok[gi]    = open_q && pre_q == '0;
    end

    assign ref_ok = !(|bank_open) && (&act_idle) && rfc_q == '0;

    always_comb begin
        rrd_d = sat_dec(rrd_q);
        ccd_d = sat_dec(ccd_q);
        rfc_d = sat_dec(rfc_q);
        if (act_go) rrd_d = mx(rrd_d, L_RRD);
        if (col_go) ccd_d = mx(ccd_d, L_CCD);
        if (ref_go) rfc_d = mx(rfc_d, L_RFC);
    end

    // Legality is judged against the flags visible in the issue cycle.
    always_comb begin
        viol_d = 1'b0;
        if (cmd_valid) begin
            if (is_illegal) begin
                viol_d = 1'b1;
            end else if (is_bank_cmd && !bank_in_range) begin
                viol_d = 1'b1;
            end else if (is_col) begin
                viol_d = !(|(rw_ok & bank_sel));
            end else if (cmd == CMD_ACTIVE) begin
                viol_d = !(|(act_ok & bank_sel));
            end else if (cmd == CMD_PRECHARGE) begin
                viol_d = !(|(pre_ok & bank_sel));
            end else if (cmd == CMD_REFRESH) begin
                viol_d = !ref_ok;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrd_q         <= '0;
            ccd_q         <= '0;
            rfc_q         <= '0;
            viol_q        <= 1'b0;
            viol_bank_q   <= '0;
            viol_sticky_q <= 1'b0;
        end else begin
            rrd_q         <= rrd_d;
            ccd_q         <= ccd_d;
            rfc_q         <= rfc_d;
            viol_q        <= viol_d;
            if (viol_d) viol_bank_q <= cmd_bank;
            viol_sticky_q <= viol_sticky_q | viol_d;
        end
    end

    assign viol        = viol_q;
    assign viol_bank   = viol_bank_q;
    assign viol_sticky = viol_sticky_q;

endmodule

// File: tb/tb_bank_timing_tracker.sv
// Directed bench for bank_timing_tracker: scenario tasks with hand-computed cycle timelines.
module tb_bank_timing_tracker;

    localparam logic [3:0] C_NOP   = 4'd0;
    localparam logic [3:0] C_READ  = 4'd1;
    localparam logic [3:0] C_REF   = 4'd5;
    localparam logic [3:0] C_ACT   = 4'd6;
    localparam logic [3:0] C_PRE   = 4'd7;
    localparam logic [3:0] C_WRA   = 4'd9;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd = 4'd0;
    logic [2:0] cmd_bank = 3'd0;
    logic [7:0] act_ok, rw_ok, pre_ok, bank_open;
    logic       ref_ok, viol, viol_sticky;
    logic [2:0] viol_bank;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bank_timing_tracker dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
        .act_ok(act_ok), .rw_ok(rw_ok), .pre_ok(pre_ok), .ref_ok(ref_ok),
        .bank_open(bank_open), .viol(viol), .viol_bank(viol_bank), .viol_sticky(viol_sticky)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [2:0] b);
        cmd_valid = v;
        cmd       = c;
        cmd_bank  = b;
    endtask

    task automatic do_reset();
        drive(1'b0, C_NOP, 3'd0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        drive(1'b0, C_NOP, 3'd0);
        rst = 1'b1;
        tick();
        n_checks++;
        if (act_ok !== 8'hFF || ref_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ok act_ok=%h ref_ok=%b exp act_ok=ff ref_ok=1", act_ok, ref_ok);
        end
        n_checks++;
        if (rw_ok !== 8'h00 || pre_ok !== 8'h00 || bank_open !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_closed rw_ok=%h pre_ok=%h open=%h exp 00/00/00", rw_ok, pre_ok, bank_open);
        end
        n_checks++;
        if (viol !== 1'b0 || viol_sticky !== 1'b0 || viol_bank !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_viol viol=%b sticky=%b bank=%0d exp 0/0/0", viol, viol_sticky, viol_bank);
        end
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_act_timing();
        do_reset();
        while (cyc <= 30) begin
            if (cyc >= 1) begin
                n_checks++;
                if (rw_ok[2] !== (cyc >= 11)) begin
                    n_fail++;
                    $display("FAIL act_rcd cyc=%0d rw_ok[2]=%b exp=%b", cyc, rw_ok[2], cyc >= 11);
                end
                n_checks++;
                if (pre_ok[2] !== (cyc >= 28)) begin
                    n_fail++;
                    $display("FAIL act_ras cyc=%0d pre_ok[2]=%b exp=%b", cyc, pre_ok[2], cyc >= 28);
                end
                n_checks++;
                if (act_ok[5] !== (cyc >= 6)) begin
                    n_fail++;
                    $display("FAIL act_rrd cyc=%0d act_ok[5]=%b exp=%b", cyc, act_ok[5], cyc >= 6);
                end
                n_checks++;
                if (bank_open !== 8'h04 || viol !== 1'b0) begin
                    n_fail++;
                    $display("FAIL act_open cyc=%0d open=%h viol=%b exp open=04 viol=0", cyc, bank_open, viol);
                end
            end
            if (cyc == 0) drive(1'b1, C_ACT, 3'd2);
            else          drive(1'b0, C_NOP, 3'd0);
            tick();
        end
        $display("test_act_timing done");
    endtask

    task automatic test_act_pre();
        do_reset();
        while (cyc <= 41) begin
            if (cyc >= 29) begin
                n_checks++;
                if (act_ok[2] !== (cyc >= 39)) begin
                    n_fail++;
                    $display("FAIL pre_rc cyc=%0d act_ok[2]=%b exp=%b", cyc, act_ok[2], cyc >= 39);
                end
                n_checks++;
                if (bank_open[2] !== 1'b0 || viol_sticky !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pre_close cyc=%0d open[2]=%b sticky=%b exp 0/0", cyc, bank_open[2], viol_sticky);
                end
            end
            if (cyc == 0)       drive(1'b1, C_ACT, 3'd2);
            else if (cyc == 28) drive(1'b1, C_PRE, 3'd2);
            else                drive(1'b0, C_NOP, 3'd0);
            tick();
        end
        $display("test_act_pre done");
    endtask

    // Bank 4 opened first so its tRCD has expired when bank 1 is read.
    task automatic test_read_merge();
        do_reset();
        while (cyc <= 36) begin
            if (cyc == 17) begin
                n_checks++;
                if (rw_ok[1] !== 1'b1 || rw_ok[4] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rd_ready cyc=17 rw_ok[1]=%b rw_ok[4]=%b exp 1/1", rw_ok[1], rw_ok[4]);
                end
            end
            if (cyc >= 18 && cyc <= 22) begin
                n_checks++;
                if (rw_ok[4] !== (cyc >= 21)) begin
                    n_fail++;
                    $display("FAIL rd_ccd cyc=%0d rw_ok[4]=%b exp=%b", cyc, rw_ok[4], cyc >= 21);
                end
            end
            if (cyc >= 18) begin
                n_checks++;
                if (pre_ok[1] !== (cyc >= 34)) begin
                    n_fail++;
                    $display("FAIL rd_merge cyc=%0d pre_ok[1]=%b exp=%b", cyc, pre_ok[1], cyc >= 34);
                end
            end
            if (cyc >= 1) begin
                n_checks++;
                if (viol !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rd_noviol cyc=%0d viol=%b exp=0", cyc, viol);
                end
            end
            if (cyc == 0)       drive(1'b1, C_ACT, 3'd4);
            else if (cyc == 6)  drive(1'b1, C_ACT, 3'd1);
            else if (cyc == 17) drive(1'b1, C_READ, 3'd1);
            else                drive(1'b0, C_NOP, 3'd0);
            tick();
        end
        $display("test_read_merge done");
    endtask

    task automatic test_wra();
        do_reset();
        while (cyc <= 48) begin
            if (cyc >= 1) begin
                n_checks++;
                if (bank_open[0] !== (cyc <= 11)) begin
                    n_fail++;
                    $display("FAIL wra_open cyc=%0d open[0]=%b exp=%b", cyc, bank_open[0], cyc <= 11);
                end
                n_checks++;
                if (act_ok[0] !== (cyc >= 46)) begin
                    n_fail++;
                    $display("FAIL wra_act cyc=%0d act_ok[0]=%b exp=%b", cyc, act_ok[0], cyc >= 46);
                end
                n_checks++;
                if (viol !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wra_noviol cyc=%0d viol=%b exp=0", cyc, viol);
                end
            end
            if (cyc == 0)       drive(1'b1, C_ACT, 3'd0);
            else if (cyc == 11) drive(1'b1, C_WRA, 3'd0);
            else                drive(1'b0, C_NOP, 3'd0);
            tick();
        end
        $display("test_wra done");
    endtask

    task automatic test_refresh();
        logic exp_ok;
        do_reset();
        while (cyc <= 90) begin
            if (cyc >= 1) begin
                exp_ok = (cyc >= 88);
                n_checks++;
                if (ref_ok !== exp_ok || act_ok !== {8{exp_ok}}) begin
                    n_fail++;
                    $display("FAIL ref_rfc cyc=%0d ref_ok=%b act_ok=%h exp=%b", cyc, ref_ok, act_ok, exp_ok);
                end
            end
            if (cyc == 0) drive(1'b1, C_REF, 3'd0);
            else          drive(1'b0, C_NOP, 3'd0);
            tick();
        end
        $display("test_refresh done");
    endtask

    // A second REFRESH inside tRFC is flagged and, its load being applied, extends the window to 50+88.
    task automatic test_refresh_overlap();
        do_reset();
        while (cyc <= 140) begin
            if (cyc >= 1) begin
                n_checks++;
                if (ref_ok !== (cyc >= 138)) begin
                    n_fail++;
                    $display("FAIL ref2_window cyc=%0d ref_ok=%b exp=%b", cyc, ref_ok, cyc >= 138);
                end
                n_checks++;
                if (viol !== (cyc == 51) || viol_sticky !== (cyc >= 51)) begin
                    n_fail++;
                    $display("FAIL ref2_viol cyc=%0d viol=%b sticky=%b exp=%b/%b", cyc, viol, viol_sticky,
                             cyc == 51, cyc >= 51);
                end
            end
            if (cyc == 51) begin
                n_checks++;
                if (viol_bank !== 3'd0) begin
                    n_fail++;
                    $display("FAIL ref2_bank viol_bank=%0d exp=0", viol_bank);
                end
            end
            if (cyc == 0 || cyc == 50) drive(1'b1, C_REF, 3'd0);
            else                       drive(1'b0, C_NOP, 3'd0);
            tick();
        end
        $display("test_refresh_overlap done");
    endtask

    task automatic test_closed_read();
        do_reset();
        while (cyc <= 5) begin
            if (cyc == 1) begin
                n_checks++;
                if (viol !== 1'b1 || viol_bank !== 3'd3 || viol_sticky !== 1'b1) begin
                    n_fail++;
                    $display("FAIL closed_rd viol=%b bank=%0d sticky=%b exp 1/3/1", viol, viol_bank, viol_sticky);
                end
            end
            if (cyc == 2 || cyc == 5) begin
                n_checks++;
                if (viol !== 1'b0 || viol_sticky !== 1'b1) begin
                    n_fail++;
                    $display("FAIL closed_pulse cyc=%0d viol=%b sticky=%b exp 0/1", cyc, viol, viol_sticky);
                end
            end
            if (cyc == 4) begin
                n_checks++;
                if (viol !== 1'b1 || viol_bank !== 3'd6 || act_ok !== 8'hFF || bank_open !== 8'h00) begin
                    n_fail++;
                    $display("FAIL illegal_code viol=%b bank=%0d act_ok=%h open=%h exp 1/6/ff/00",
                             viol, viol_bank, act_ok, bank_open);
                end
            end
            if (cyc == 0)      drive(1'b1, C_READ, 3'd3);
            else if (cyc == 3) drive(1'b1, 4'd12, 3'd6);
            else               drive(1'b0, C_NOP, 3'd0);
            tick();
        end
        $display("test_closed_read done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        while (cyc <= 4) begin
            if (cyc == 0)      drive(1'b1, C_ACT, 3'd2);
            else if (cyc == 1) drive(1'b1, C_ACT, 3'd3);
            else               drive(1'b0, C_NOP, 3'd0);
            tick();
        end
        n_checks++;
        if (bank_open !== 8'h0C || viol_sticky !== 1'b1 || act_ok !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_pre open=%h sticky=%b act_ok=%h exp 0c/1/00", bank_open, viol_sticky, act_ok);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (act_ok !== 8'hFF || rw_ok !== 8'h00 || pre_ok !== 8'h00 || ref_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst_ok act=%h rw=%h pre=%h ref=%b exp ff/00/00/1", act_ok, rw_ok, pre_ok, ref_ok);
        end
        n_checks++;
        if (bank_open !== 8'h00 || viol_sticky !== 1'b0 || viol !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_state open=%h sticky=%b viol=%b exp 00/0/0", bank_open, viol_sticky, viol);
        end
        #1;
        rst = 1'b0;
        $display("test_reset_mid done");
    endtask

    // ACTs on consecutive cycles: each one inside tRRD is flagged and re-extends the tRRD window.
    task automatic test_back_to_back();
        do_reset();
        while (cyc <= 9) begin
            if (cyc == 2 || cyc == 3) begin
                n_checks++;
                if (viol !== 1'b1 || viol_bank !== 3'(cyc - 1)) begin
                    n_fail++;
                    $display("FAIL b2b_viol cyc=%0d viol=%b bank=%0d exp 1/%0d", cyc, viol, viol_bank, cyc - 1);
                end
            end
            if (cyc >= 3) begin
                n_checks++;
                if (bank_open !== 8'h07) begin
                    n_fail++;
                    $display("FAIL b2b_open cyc=%0d open=%h exp=07", cyc, bank_open);
                end
                n_checks++;
                if (act_ok[7] !== (cyc >= 8)) begin
                    n_fail++;
                    $display("FAIL b2b_rrd cyc=%0d act_ok[7]=%b exp=%b", cyc, act_ok[7], cyc >= 8);
                end
            end
            if (cyc <= 2) drive(1'b1, C_ACT, 3'(cyc));
            else          drive(1'b0, C_NOP, 3'd0);
            tick();
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_act_timing();
        test_act_pre();
        test_read_merge();
        test_wra();
        test_refresh();
        test_refresh_overlap();
        test_closed_read();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
